// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, ALU/mux selects,
// FSM state encoding and the per-state control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b01;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_BOOT, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
        ST_EXEC, ST_ALUWB, ST_BRANCH, ST_ADDIEX, ST_ADDIWB, ST_JUMP, ST_ILLEGAL,
        ST_TRAP
    } state_t;

    // Ungated control word; mem_ready gating is applied in the top.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return ST_EXEC;
            OP_LW, OP_SW: return ST_MEMADR;
            OP_BEQ:       return ST_BRANCH;
            OP_ADDI:      return ST_ADDIEX;
            OP_J:         return ST_JUMP;
            default:      return ST_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decode for the multicycle MIPS control FSM.
// ILLEGAL_TRAP_EN enables the illegal_instr flag in the TRAP state.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                ctrl.retire   = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: ctrl.illegal = 1'b1;
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to make illegal opcodes lock the FSM in TRAP until reset.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             instr_retired,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_instr
);

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    ctrl_t            cw;
    logic             ready_eff;
    logic             retire;

    assign ready_eff = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    mips_ctrl_outdec u_outdec (
        .state (state_reg),
        .ctrl  (cw)
    );

    // Only FETCH (IR/PC load) and MEMWR (retire) complete on the memory's ready cycle.
    assign retire        = cw.retire & ((state_reg != ST_MEMWR) | ready_eff);
    assign ir_write      = cw.ir_write & ready_eff;
    assign pc_write      = cw.pc_write & ((state_reg != ST_FETCH) | ready_eff);
    assign instr_retired = retire;

    assign alu_op        = cw.alu_op;
    assign alu_src_a     = cw.alu_src_a;
    assign alu_src_b     = cw.alu_src_b;
    assign pc_src        = cw.pc_src;
    assign i_or_d        = cw.i_or_d;
    assign mem_read      = cw.mem_read;
    assign mem_write     = cw.mem_write;
    assign branch        = cw.branch;
    assign reg_dst       = cw.reg_dst;
    assign mem_to_reg    = cw.mem_to_reg;
    assign reg_write     = cw.reg_write;
    assign illegal_instr = cw.illegal;
    assign instr_count   = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            count_reg <= '0;
        end else begin
            if (retire)
                count_reg <= count_reg + CNT_W'(1);
            case (state_reg)
                ST_BOOT:    state_reg <= ST_FETCH;
                ST_FETCH:   if (ready_eff) state_reg <= ST_DECODE;
                ST_DECODE:  state_reg <= decode_next(opcode);
                ST_MEMADR:  state_reg <= (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:   if (ready_eff) state_reg <= ST_MEMWB;
                ST_MEMWR:   if (ready_eff) state_reg <= ST_FETCH;
                ST_EXEC:    state_reg <= ST_ALUWB;
                ST_ADDIEX:  state_reg <= ST_ADDIWB;
                ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP:
                            state_reg <= ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
                ST_ILLEGAL: state_reg <= ST_TRAP;
`else
                ST_ILLEGAL: state_reg <= ST_FETCH;
`endif
                ST_TRAP:    state_reg <= ST_TRAP;
                default:    state_reg <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: a phase-sequence model per instruction class predicts
// every cycle's control word and the retired-instruction count.
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    localparam int P_BOOT = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4;
    localparam int P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9;
    localparam int P_ADDIEX = 10, P_ADDIWB = 11, P_JUMP = 12, P_NOP = 13, P_TRAP = 14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, rst_n_s = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;

    logic [1:0]  alu_op_m, alu_src_b_m, pc_src_m, alu_op_s, alu_src_b_s, pc_src_s;
    logic        alu_src_a_m, i_or_d_m, mem_read_m, mem_write_m, ir_write_m, pc_write_m;
    logic        branch_m, reg_dst_m, mem_to_reg_m, reg_write_m, retired_m, illegal_m;
    logic        alu_src_a_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s, pc_write_s;
    logic        branch_s, reg_dst_s, mem_to_reg_s, reg_write_s, retired_s, illegal_s;
    logic [31:0] count_m;
    logic [3:0]  count_s;

    int          total = 0, bad = 0;
    bit          use_small = 1'b0, rand_mode = 1'b0;
    int          mem_stall = 0, cycles = 0;
    logic [31:0] m_count = '0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op_m), .alu_src_a(alu_src_a_m), .alu_src_b(alu_src_b_m), .pc_src(pc_src_m),
        .i_or_d(i_or_d_m), .mem_read(mem_read_m), .mem_write(mem_write_m),
        .ir_write(ir_write_m), .pc_write(pc_write_m), .branch(branch_m), .reg_dst(reg_dst_m),
        .mem_to_reg(mem_to_reg_m), .reg_write(reg_write_m), .instr_retired(retired_m),
        .instr_count(count_m), .illegal_instr(illegal_m)
    );

    mips_multicycle_control #(.CNT_W(4), .MEM_HANDSHAKE(0)) dut_small (
        .clk(clk), .rst_n(rst_n_s), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op_s), .alu_src_a(alu_src_a_s), .alu_src_b(alu_src_b_s), .pc_src(pc_src_s),
        .i_or_d(i_or_d_s), .mem_read(mem_read_s), .mem_write(mem_write_s),
        .ir_write(ir_write_s), .pc_write(pc_write_s), .branch(branch_s), .reg_dst(reg_dst_s),
        .mem_to_reg(mem_to_reg_s), .reg_write(reg_write_s), .instr_retired(retired_s),
        .instr_count(count_s), .illegal_instr(illegal_s)
    );

    wire [18:0] word_m = {alu_op_m, alu_src_a_m, alu_src_b_m, pc_src_m, i_or_d_m, mem_read_m,
                          mem_write_m, ir_write_m, pc_write_m, branch_m, reg_dst_m,
                          mem_to_reg_m, reg_write_m, retired_m, illegal_m};
    wire [18:0] word_s = {alu_op_s, alu_src_a_s, alu_src_b_s, pc_src_s, i_or_d_s, mem_read_s,
                          mem_write_s, ir_write_s, pc_write_s, branch_s, reg_dst_s,
                          mem_to_reg_s, reg_write_s, retired_s, illegal_s};
    wire [18:0] obs_word = use_small ? word_s : word_m;
    wire [31:0] obs_cnt  = use_small ? {28'b0, count_s} : count_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs of each instruction phase, written from the phase descriptions.
    function automatic logic [18:0] exp_word(input int ph, input bit rdy);
        logic [1:0] aop = 0, sb = 0, ps = 0;
        bit sa = 0, iod = 0, mr = 0, mw = 0, irw = 0, pcw = 0, br = 0;
        bit rd = 0, mtr = 0, rw = 0, ret = 0, ill = 0;
        case (ph)
            P_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            P_DECODE: sb = 2'b11;
            P_MEMADR, P_ADDIEX: begin sa = 1; sb = 2'b10; end
            P_MEMRD:  begin mr = 1; iod = 1; end
            P_MEMWB:  begin rw = 1; mtr = 1; ret = 1; end
            P_MEMWR:  begin mw = 1; iod = 1; ret = rdy; end
            P_EXEC:   begin sa = 1; aop = 2'b01; end
            P_ALUWB:  begin rw = 1; rd = 1; ret = 1; end
            P_BRANCH: begin sa = 1; aop = 2'b10; ps = 2'b01; br = 1; ret = 1; end
            P_ADDIWB: begin rw = 1; ret = 1; end
            P_JUMP:   begin ps = 2'b10; pcw = 1; ret = 1; end
            P_TRAP:   ill = 1;
            default:  ;
        endcase
        return {aop, sa, sb, ps, iod, mr, mw, irw, pcw, br, rd, mtr, rw, ret, ill};
    endfunction

    function automatic bit is_wait(input int ph);
        return (ph == P_FETCH) || (ph == P_MEMRD) || (ph == P_MEMWR);
    endfunction

    // One phase: repeats while a memory phase sees no (effective) ready.
    task automatic do_phase(input int ph, input logic [5:0] op);
        bit rdy, eff, done;
        int lows = 0;
        logic [18:0] e;
        do begin
            if (use_small) rdy = 1'b0;
            else if (is_wait(ph) && ph != P_FETCH && mem_stall > 0) begin
                rdy = 1'b0;
                mem_stall--;
            end else if (rand_mode && lows < 4) rdy = ($urandom_range(0, 2) != 0);
            else rdy = 1'b1;
            if (!rdy) lows++;
            opcode    = (ph == P_DECODE || ph == P_MEMADR) ? op : 6'($urandom);
            mem_ready = rdy;
            eff       = use_small ? 1'b1 : rdy;
            #1;
            e = exp_word(ph, eff);
            chk("ctl", 32'(obs_word), 32'(e));
            chk("cnt", obs_cnt, use_small ? (m_count & 32'hF) : m_count);
            if (e[1]) m_count++;
            cycles++;
            @(posedge clk);
            #2;
            done = !is_wait(ph) || eff;
        end while (!done);
    endtask

    task automatic run_instr(input logic [5:0] op);
        cycles = 0;
        do_phase(P_FETCH, op);
        do_phase(P_DECODE, op);
        case (op)
            OP_R:    begin do_phase(P_EXEC, op); do_phase(P_ALUWB, op); end
            OP_LW:   begin do_phase(P_MEMADR, op); do_phase(P_MEMRD, op); do_phase(P_MEMWB, op); end
            OP_SW:   begin do_phase(P_MEMADR, op); do_phase(P_MEMWR, op); end
            OP_BEQ:  do_phase(P_BRANCH, op);
            OP_ADDI: begin do_phase(P_ADDIEX, op); do_phase(P_ADDIWB, op); end
            OP_J:    do_phase(P_JUMP, op);
            default: do_phase(P_NOP, op);
        endcase
        $display("instr op=%b small=%0d cycles=%0d count=%0d", op, use_small, cycles, obs_cnt);
    endtask

    task automatic do_reset();
        if (use_small) rst_n_s = 1'b0;
        else rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(obs_word), 32'h0);
        chk("rst_cnt", obs_cnt, 32'h0);
        @(posedge clk);
        #2;
        if (use_small) rst_n_s = 1'b1;
        else rst_n = 1'b1;
        m_count = '0;
        do_phase(P_BOOT, 6'h0);
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

        @(posedge clk);
        #2;
        do_reset();

        run_instr(OP_R);
        mem_stall = 3;
        run_instr(OP_LW);
        run_instr(OP_BEQ);
        run_instr(OP_J);
        run_instr(OP_SW);
        run_instr(OP_ADDI);

        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int k = $urandom_range(0, 6);
`ifdef ILLEGAL_TRAP_EN
            op = (k == 6) ? OP_J : ops[k];
`else
            op = (k == 6) ? (6'b110000 | 6'($urandom_range(0, 15))) : ops[k];
`endif
            run_instr(op);
        end
        rand_mode = 1'b0;

`ifdef ILLEGAL_TRAP_EN
        do_phase(P_FETCH, 6'b111111);
        do_phase(P_DECODE, 6'b111111);
        do_phase(P_NOP, 6'b111111);
        for (int i = 0; i < 20; i++) do_phase(P_TRAP, 6'b111111);
        do_reset();
`else
        run_instr(6'b111111);
`endif

        // Reset asserted while a store is waiting on memory.
        run_instr(OP_J);
        do_phase(P_FETCH, OP_SW);
        do_phase(P_DECODE, OP_SW);
        do_phase(P_MEMADR, OP_SW);
        opcode = OP_SW;
        mem_ready = 1'b0;
        #1;
        chk("memwr_wait", 32'(mem_write_m), 32'h1);
        @(posedge clk);
        #2;
        do_reset();
        run_instr(OP_R);

        use_small = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) run_instr(OP_J);
        chk("wrap", obs_cnt, 32'h0);
        run_instr(OP_LW);
        chk("lw_nohs", obs_cnt, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
